// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared types and constants for the instruction-fetch stage.
//               fetch_state_t    - fetch FSM states
//               INSTR_WIDTH      - width of one instruction word
//               LINE_OFFSET_BITS - byte-offset bits inside one fetch line
//               NOP_INSTR        - canonical no-op for downstream flush logic
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,  // line request on the memory port
    WAIT = 2'd1,  // request accepted, waiting for the response
    HAVE = 2'd2   // line buffered, instructions being handed to decode
  } fetch_state_t;

  localparam int INSTR_WIDTH      = 32;
  localparam int LINE_OFFSET_BITS = 3;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Bus bundle of the fetch stage.
//               Memory side : mem_req_valid/ready/addr, mem_resp_valid/data
//               Decode side : stage1_valid/instruction_bits/pc, decode_stall
//               Redirect    : redirect_valid, redirect_pc
//               master - the fetch stage view; slave - the environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
  parameter int ADDR_WIDTH     = 64,
  parameter int BUS_DATA_WIDTH = 64
);

  logic                          mem_req_valid;
  logic                          mem_req_ready;
  logic [ADDR_WIDTH-1:0]         mem_req_addr;
  logic                          mem_resp_valid;
  logic [BUS_DATA_WIDTH-1:0]     mem_resp_data;
  logic                          stage1_valid;
  logic [BUS_DATA_WIDTH/2-1:0]   stage1_instruction_bits;
  logic [ADDR_WIDTH-1:0]         stage1_pc;
  logic                          decode_stall;
  logic                          redirect_valid;
  logic [ADDR_WIDTH-1:0]         redirect_pc;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_data,
    output stage1_valid, stage1_instruction_bits, stage1_pc,
    input  decode_stall,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_data,
    input  stage1_valid, stage1_instruction_bits, stage1_pc,
    output decode_stall,
    output redirect_valid, redirect_pc
  );

endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/fetch_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_line_buf
// Description : One-line instruction buffer with word select.
//   clk       in   stage clock
//   reset     in   asynchronous active-low reset, clears the line
//   load      in   capture data_in into the buffer
//   data_in   in   fetched line (word 0 in the low half)
//   sel       in   word select, pc[2]: 0 = low word, 1 = high word
//   instr_out out  selected instruction word
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_line_buf
  import fetch_stage_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  input  wire logic                      load,
  input  wire logic [BUS_DATA_WIDTH-1:0] data_in,
  input  wire logic                      sel,
  output logic      [INSTR_WIDTH-1:0]    instr_out
);

  logic [BUS_DATA_WIDTH-1:0] r_line_buf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_line_buf <= '0;
    end else if (load) begin
      r_line_buf <= data_in;
    end
  end

  assign instr_out = sel ? r_line_buf[2*INSTR_WIDTH-1:INSTR_WIDTH]
                         : r_line_buf[INSTR_WIDTH-1:0];

endmodule : fetch_line_buf
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Reads one aligned 64-bit line at a
//               time, buffers it and hands out one instruction per cycle to
//               decode. A redirect reloads the PC and flushes the buffer and
//               any outstanding read.
//   clk    in   stage clock
//   reset  in   asynchronous active-low reset
//   bus    --   fetch_stage_if.master: memory request/response port,
//               decode handshake (stage1_*, decode_stall), redirect input
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          BUS_DATA_WIDTH = 64,
  parameter logic [63:0] RESET_PC       = 64'h0,
  parameter int          ADDR_WIDTH     = 64
) (
  input wire logic       clk,
  input wire logic       reset,
  fetch_stage_if.master  bus
);

  localparam logic [ADDR_WIDTH-1:0] c_reset_pc    = RESET_PC[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] c_instr_bytes = ADDR_WIDTH'(INSTR_WIDTH / 8);

  fetch_state_t            r_state;
  fetch_state_t            w_state_next;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [ADDR_WIDTH-1:0]   w_pc_next;
  logic                    r_drop;
  logic                    w_drop_next;
  logic                    w_load;
  logic                    w_consume;
  logic [INSTR_WIDTH-1:0]  w_instr;
  logic [ADDR_WIDTH-1:0]   w_redirect_target;
  logic                    w_unused;

  // Redirect targets are word aligned; the two low bits carry no information.
  assign w_redirect_target = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign w_unused          = ^bus.redirect_pc[1:0];

  // A redirect in the same cycle wins over handing the instruction to decode.
  assign w_consume = (r_state == HAVE) && !bus.decode_stall && !bus.redirect_valid;

  // --------------------------------------------------------------------------
  // State register (FSM state, pc, drop flag)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= REQ;
      r_pc    <= c_reset_pc;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_drop  <= w_drop_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_drop_next  = r_drop;
    w_load       = 1'b0;

    case (r_state)
      REQ: begin
        if (bus.mem_req_ready) begin
          // The read is already in flight when a redirect lands on the
          // accept cycle, so its data must be thrown away on return.
          w_state_next = WAIT;
          w_drop_next  = bus.redirect_valid;
        end
      end

      WAIT: begin
        if (bus.mem_resp_valid) begin
          w_drop_next = 1'b0;
          if (r_drop || bus.redirect_valid) begin
            w_state_next = REQ;
          end else begin
            w_state_next = HAVE;
            w_load       = 1'b1;
          end
        end else if (bus.redirect_valid) begin
          w_drop_next = 1'b1;
        end
      end

      HAVE: begin
        if (bus.redirect_valid) begin
          w_state_next = REQ;
        end else if (w_consume) begin
          w_pc_next = r_pc + c_instr_bytes;
          // The upper word was the last one in the line.
          if (r_pc[2]) begin
            w_state_next = REQ;
          end
        end
      end

      default: begin
        w_state_next = REQ;
      end
    endcase

    if (bus.redirect_valid) begin
      w_pc_next = w_redirect_target;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic (registers only, plus the reset gate on the request)
  // --------------------------------------------------------------------------
  always_comb begin
    bus.mem_req_valid           = 1'b0;
    bus.mem_req_addr            = {r_pc[ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    bus.stage1_valid            = 1'b0;
    bus.stage1_instruction_bits = '0;
    bus.stage1_pc               = r_pc;

    case (r_state)
      // The reset state is REQ; the request must stay quiet until reset
      // is released, so it is qualified by the reset input itself.
      REQ: begin
        bus.mem_req_valid = reset;
      end
      HAVE: begin
        bus.stage1_valid            = 1'b1;
        bus.stage1_instruction_bits = w_instr;
      end
      default: begin
        bus.mem_req_valid = 1'b0;
      end
    endcase
  end

  fetch_line_buf #(
    .BUS_DATA_WIDTH (BUS_DATA_WIDTH)
  ) u_line_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .data_in   (bus.mem_resp_data),
    .sel       (r_pc[2]),
    .instr_out (w_instr)
  );

endmodule : fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage feeding the decode stage.
- Issues one 64-bit aligned line read at a time on the instruction memory port and holds the returned line in a one-line buffer.
- Presents one 32-bit instruction plus its PC per cycle to decode under a valid/stall handshake.
- Accepts a redirect (branch/jump target) from a later stage, which flushes the buffer and any outstanding read.

Parameters:
- BUS_DATA_WIDTH, 64, memory response width; one line holds BUS_DATA_WIDTH/32 = 2 instructions.
- RESET_PC, 64'h0, PC loaded at reset.
- ADDR_WIDTH, 64, PC and bus address width.

Ports:
- clk  in  1  stage clock.
- reset  in  1  asynchronous, active-low reset.
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_req_addr  out  ADDR_WIDTH  line address, pc with bits [2:0] = 0.
- mem_resp_valid  in  1  read data valid; single cycle, in order, at most one outstanding.
- mem_resp_data  in  BUS_DATA_WIDTH  line data; bits [31:0] hold addr+0, bits [63:32] hold addr+4.
- stage1_valid  out  1  instruction/PC valid to decode.
- stage1_instruction_bits  out  BUS_DATA_WIDTH/2  instruction word.
- stage1_pc  out  ADDR_WIDTH  PC of the instruction.
- decode_stall  in  1  decode cannot consume this cycle.
- redirect_valid  in  1  load new PC.
- redirect_pc  in  ADDR_WIDTH  target; bits [1:0] are ignored and forced to 0.

Behaviour:
- State: pc reg, line_buf (BUS_DATA_WIDTH), drop flag, FSM {REQ, WAIT, HAVE}.
- Reset (reset=0, async): state=REQ, pc=RESET_PC, drop=0, line_buf=0. While in reset: mem_req_valid=0, stage1_valid=0, stage1_instruction_bits=0, stage1_pc=RESET_PC.
- REQ: mem_req_valid=1, mem_req_addr={pc[63:3],3'b0}.
  - mem_req_ready=1 -> WAIT.
  - The address holds stable while ready=0.
- WAIT: mem_req_valid=0. On mem_resp_valid:
  - drop=1: discard data, clear drop, go to REQ.
  - drop=0: line_buf<=data, go to HAVE.
- HAVE: stage1_valid=1, stage1_pc=pc, stage1_instruction_bits = pc[2] ? line_buf[63:32] : line_buf[31:0]. Combinational from registers.
  - Consume = stage1_valid & !decode_stall & !redirect_valid.
  - On consume: pc<=pc+4. If pc[2] was 1, the line is exhausted -> REQ; otherwise stay in HAVE.
  - A stall holds all outputs unchanged.
- Redirect has the highest priority, evaluated every cycle:
  - pc<={redirect_pc[63:2],2'b0}.
  - From REQ or HAVE: go to REQ. An instruction shown that cycle is not consumed. A request accepted the same cycle (REQ with ready=1) sets drop=1 and goes to WAIT instead.
  - From WAIT: set drop=1 and stay in WAIT. A response arriving in the same cycle counts as dropped -> REQ.
- mem_resp_valid outside WAIT is ignored.
- Redirect to an odd word (pc[2]=1): the line is fetched, and only the upper half is delivered.
- PC wraps modulo 2^ADDR_WIDTH. No fault is raised.
- Latency: req accepted at cycle t, resp at cycle t+N -> stage1_valid at t+N+1. Back-to-back lines cost 1 REQ cycle plus memory latency. No prefetch.
- Reset asserted mid-operation: immediate return to reset values. A late response after reset release is ignored unless the FSM is in WAIT; the memory side must be reset together with this stage.

Decomposition:
- Shared package: fetch_state_t enum {REQ, WAIT, HAVE}; constant INSTR_WIDTH=32; constant LINE_OFFSET_BITS=3; constant NOP_INSTR=32'h00000013 for use by downstream flush logic.
- One natural sub-module: fetch_line_buf. It holds line_buf and the word select by pc[2], and exposes load, data_in, sel, and instr_out.

Test Plan:
- Reset release with RESET_PC=0x1000, ready=1, resp 2 cycles after accept with data 0x00500093_00100093 -> addr 0x1000; decode sees 0x00100093@0x1000 then 0x00500093@0x1004 on consecutive cycles; next req addr=0x1008.
- decode_stall held 3 cycles while in HAVE -> stage1_valid/pc/bits constant; pc advances only on the first unstalled cycle.
- redirect_valid with redirect_pc=0x2006 while in WAIT, then resp arrives -> that response is dropped; next req addr=0x2000; first delivered pc=0x2004 (upper half).
- Redirect coincident with mem_resp_valid in WAIT -> data discarded; FSM is in REQ the next cycle with the new line address.
- mem_req_ready held low 5 cycles -> mem_req_valid=1 and the address stable throughout; a spurious mem_resp_valid in REQ is ignored.
- reset asserted in HAVE mid-line -> outputs return to reset values asynchronously; after release the fetch restarts at RESET_PC.
